// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap controller: CSR map, mstatus
// bit positions, mtvec modes and the controller FSM states.
package trap_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;
   localparam logic [11:0] CSR_MIP     = 12'h344;

   localparam int MSTATUS_MIE_BIT  = 3;
   localparam int MSTATUS_MPIE_BIT = 7;

   typedef enum logic [1:0] {
      MTVEC_DIRECT   = 2'd0,
      MTVEC_VECTORED = 2'd1
   } mtvec_mode_e;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } trap_state_e;

   // Reserved modes 2/3 collapse to direct.
   function automatic logic [1:0] mtvec_legal_mode(input logic [1:0] mode);
      return (mode == 2'(MTVEC_VECTORED)) ? 2'(MTVEC_VECTORED) : 2'(MTVEC_DIRECT);
   endfunction

endpackage

// File: rtl/trap_controller_prio_enc.sv
// Lowest-set-bit priority encoder with a valid flag; shared by the exception
// and interrupt paths of the trap controller.
module prio_enc #(
   parameter int W  = 16,
   parameter int IW = (W > 1) ? $clog2(W) : 1
) (
   input  logic [W-1:0]  req,
   output logic          valid,
   output logic [IW-1:0] idx
);

   always_comb begin
      valid = |req;
      idx   = '0;
      // Scan downward so the lowest set bit is the last one written.
      for (int i = W - 1; i >= 0; i--) begin
         if (req[i]) idx = IW'(i);
      end
   end

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap unit: prioritised exceptions/interrupts, mret, owned CSRs
// and a post-redirect drain. Define TRAP_MTVAL_EN to add tval_i and mtval.
//
// state | meaning
// RUN   | normal operation, traps and mret are decided every cycle
// DRAIN | pipeline draining after a redirect; exc/irq/mret ignored
module trap_controller
   import trap_pkg::*;
#(
   parameter int           N            = 64,
   parameter int           NUM_EXC      = 16,
   parameter int           NUM_IRQ      = 16,
   parameter int           DRAIN_CYCLES = 3,
   parameter logic [N-1:0] RESET_VEC    = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_EXC-1:0] exc_i,
   input  logic [NUM_IRQ-1:0] irq_i,
   input  logic               mret_i,
   input  logic [N-1:0]       pc_i,
`ifdef TRAP_MTVAL_EN
   input  logic [N-1:0]       tval_i,
`endif
   input  logic [11:0]        csr_addr_i,
   input  logic               csr_we_i,
   input  logic [N-1:0]       csr_wdata_i,
   output logic [N-1:0]       csr_rdata_o,
   output logic               trap_o,
   output logic               redirect_o,
   output logic [N-1:0]       target_o,
   output logic               busy_o,
   output logic [N-1:0]       mcause_o,
   output logic [N-1:0]       mepc_o,
   output logic [N-1:0]       mtvec_o
);

   localparam int EXC_IW = (NUM_EXC > 1) ? $clog2(NUM_EXC) : 1;
   localparam int IRQ_IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
   localparam int CNT_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

   trap_state_e        state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic               mstatus_mie_q, mstatus_mpie_q;
   logic [NUM_IRQ-1:0] mie_q, mip_q;
   logic [N-1:0]       mtvec_q, mepc_q, mcause_q;
   logic               trap_q, redirect_q;
   logic [N-1:0]       target_q;
`ifdef TRAP_MTVAL_EN
   logic [N-1:0]       mtval_q;
`endif

   logic               exc_valid, irq_valid;
   logic [EXC_IW-1:0]  exc_idx;
   logic [IRQ_IW-1:0]  irq_idx;
   logic               in_run, take_exc, take_irq, take_trap, take_mret;
   logic [N-1:0]       trap_code, trap_cause, trap_target;
   logic               wr_mstatus, wr_mie, wr_mtvec, wr_mepc, wr_mcause;

   prio_enc #(.W(NUM_EXC), .IW(EXC_IW)) u_exc_enc (
      .req   (exc_i),
      .valid (exc_valid),
      .idx   (exc_idx)
   );

   prio_enc #(.W(NUM_IRQ), .IW(IRQ_IW)) u_irq_enc (
      .req   (mip_q & mie_q),
      .valid (irq_valid),
      .idx   (irq_idx)
   );

   always_comb begin
      in_run      = (state_q == ST_RUN);
      take_exc    = in_run && exc_valid;
      take_irq    = in_run && !exc_valid && mstatus_mie_q && irq_valid;
      take_trap   = take_exc || take_irq;
      take_mret   = in_run && mret_i && !take_trap;
      trap_code   = take_exc ? N'(exc_idx) : N'(irq_idx);
      trap_cause  = trap_code | (N'(take_irq) << (N - 1));
      // Vector offset applies to interrupts only; exceptions always use the base.
      trap_target = {mtvec_q[N-1:2], 2'b00} +
                    (((mtvec_q[1:0] == 2'(MTVEC_VECTORED)) && take_irq) ? (trap_code << 2) : '0);
   end

   always_comb begin
      wr_mstatus = csr_we_i && (csr_addr_i == CSR_MSTATUS);
      wr_mie     = csr_we_i && (csr_addr_i == CSR_MIE);
      wr_mtvec   = csr_we_i && (csr_addr_i == CSR_MTVEC);
      wr_mepc    = csr_we_i && (csr_addr_i == CSR_MEPC);
      wr_mcause  = csr_we_i && (csr_addr_i == CSR_MCAUSE);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:   if (take_trap || take_mret) state_d = ST_DRAIN;
         ST_DRAIN: if (cnt_q == '0) state_d = ST_RUN;
         default:  state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_RUN)
            cnt_q <= CNT_LOAD;
         else if (cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mie_q          <= '0;
         mip_q          <= '0;
         mtvec_q        <= RESET_VEC;
         mepc_q         <= '0;
         mcause_q       <= '0;
         trap_q         <= 1'b0;
         redirect_q     <= 1'b0;
         target_q       <= '0;
      end else begin
         mip_q      <= irq_i;
         trap_q     <= take_trap;
         redirect_q <= take_trap || take_mret;

         if (wr_mie)   mie_q   <= csr_wdata_i[NUM_IRQ-1:0];
         if (wr_mtvec) mtvec_q <= {csr_wdata_i[N-1:2], mtvec_legal_mode(csr_wdata_i[1:0])};

         // A trap or mret owns the registers it updates; a same-cycle CSR write loses.
         if (take_trap) begin
            mepc_q   <= pc_i & ~N'(3);
            mcause_q <= trap_cause;
         end else begin
            if (wr_mepc)   mepc_q   <= csr_wdata_i & ~N'(3);
            if (wr_mcause) mcause_q <= csr_wdata_i;
         end

         if (take_trap) begin
            mstatus_mpie_q <= mstatus_mie_q;
            mstatus_mie_q  <= 1'b0;
         end else if (take_mret) begin
            mstatus_mie_q  <= mstatus_mpie_q;
            mstatus_mpie_q <= 1'b1;
         end else if (wr_mstatus) begin
            mstatus_mie_q  <= csr_wdata_i[MSTATUS_MIE_BIT];
            mstatus_mpie_q <= csr_wdata_i[MSTATUS_MPIE_BIT];
         end

         if (take_trap)
            target_q <= trap_target;
         else if (take_mret)
            target_q <= mepc_q;
      end
   end

`ifdef TRAP_MTVAL_EN
   always_ff @(posedge clk) begin
      if (reset)
         mtval_q <= '0;
      else if (take_trap)
         mtval_q <= take_exc ? tval_i : '0;
      else if (csr_we_i && (csr_addr_i == CSR_MTVAL))
         mtval_q <= csr_wdata_i;
   end
`endif

   always_comb begin
      csr_rdata_o = '0;
      case (csr_addr_i)
         CSR_MSTATUS: begin
            csr_rdata_o[MSTATUS_MIE_BIT]  = mstatus_mie_q;
            csr_rdata_o[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
         end
         CSR_MIE:     csr_rdata_o[NUM_IRQ-1:0] = mie_q;
         CSR_MTVEC:   csr_rdata_o = mtvec_q;
         CSR_MEPC:    csr_rdata_o = mepc_q;
         CSR_MCAUSE:  csr_rdata_o = mcause_q;
`ifdef TRAP_MTVAL_EN
         CSR_MTVAL:   csr_rdata_o = mtval_q;
`endif
         CSR_MIP:     csr_rdata_o[NUM_IRQ-1:0] = mip_q;
         default:     csr_rdata_o = '0;
      endcase
   end

   assign trap_o     = trap_q;
   assign redirect_o = redirect_q;
   assign target_o   = target_q;
   assign busy_o     = (state_q == ST_DRAIN);
   assign mcause_o   = mcause_q;
   assign mepc_o     = mepc_q;
   assign mtvec_o    = mtvec_q;

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: CSR vector table, directed trap/mret
// sequences, then randomized traffic against a behavioural reference model.
module tb_trap_controller;

   localparam int N  = 64;
   localparam int NE = 16;
   localparam int NI = 16;
   localparam int DC = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic [NE-1:0] exc;
   logic [NI-1:0] irq;
   logic          mret;
   logic [N-1:0]  pc;
   logic [11:0]   addr;
   logic          we;
   logic [N-1:0]  wdata;
   logic [N-1:0]  rdata;
   logic          trap, redir, busy;
   logic [N-1:0]  target, mcause, mepc, mtvec;
`ifdef TRAP_MTVAL_EN
   logic [N-1:0]  tval;
`endif

   always #5 clk = ~clk;

   trap_controller #(.N(N), .NUM_EXC(NE), .NUM_IRQ(NI), .DRAIN_CYCLES(DC), .RESET_VEC('0)) dut (
      .clk         (clk),
      .reset       (reset),
      .exc_i       (exc),
      .irq_i       (irq),
      .mret_i      (mret),
      .pc_i        (pc),
`ifdef TRAP_MTVAL_EN
      .tval_i      (tval),
`endif
      .csr_addr_i  (addr),
      .csr_we_i    (we),
      .csr_wdata_i (wdata),
      .csr_rdata_o (rdata),
      .trap_o      (trap),
      .redirect_o  (redir),
      .target_o    (target),
      .busy_o      (busy),
      .mcause_o    (mcause),
      .mepc_o      (mepc),
      .mtvec_o     (mtvec)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      exc  = '0;
      mret = 1'b0;
      we   = 1'b0;
   endtask

   task automatic csr_wr(input logic [11:0] a, input logic [N-1:0] d);
      we = 1'b1; addr = a; wdata = d;
      tick();
      we = 1'b0;
   endtask

   task automatic chk_rd(input string name, input logic [11:0] a, input logic [N-1:0] e);
      addr = a;
      #1;
      check(name, rdata, e);
   endtask

   // ---------------- reference model (architectural view, one step per clock) ----
   bit            m_mie, m_mpie;
   logic [NI-1:0] m_ie, m_ip;
   logic [N-1:0]  m_tvec, m_epc, m_cause, m_tval;
   int            m_drain;
   bit            e_trap, e_redir;
   logic [N-1:0]  e_target;
   // scratch for the model step
   bit            s_trap, s_async, s_mret, s_busy, o_mie, o_mpie;
   int            s_code;
   logic [N-1:0]  o_tvec, o_epc;

   always @(posedge clk) begin
      if (reset) begin
         m_mie = 0; m_mpie = 0; m_ie = '0; m_ip = '0;
         m_tvec = '0; m_epc = '0; m_cause = '0; m_tval = '0;
         m_drain = 0; e_trap = 0; e_redir = 0; e_target = '0;
      end else begin
         o_mie = m_mie; o_mpie = m_mpie; o_tvec = m_tvec; o_epc = m_epc;
         s_busy = (m_drain > 0);
         s_trap = 0; s_async = 0; s_code = 0;
         if (!s_busy) begin
            for (int i = 0; i < NE; i++)
               if (!s_trap && exc[i]) begin s_trap = 1; s_code = i; end
            if (!s_trap && m_mie)
               for (int i = 0; i < NI; i++)
                  if (!s_trap && m_ip[i] && m_ie[i]) begin s_trap = 1; s_async = 1; s_code = i; end
         end
         s_mret = !s_busy && mret && !s_trap;

         if (we) begin
            case (addr)
               12'h300: begin m_mie = wdata[3]; m_mpie = wdata[7]; end
               12'h304: m_ie = wdata[NI-1:0];
               12'h305: m_tvec = {wdata[N-1:2], 2'b00} | ((wdata[1:0] == 2'd1) ? 64'd1 : 64'd0);
               12'h341: m_epc = {wdata[N-1:2], 2'b00};
               12'h342: m_cause = wdata;
`ifdef TRAP_MTVAL_EN
               12'h343: m_tval = wdata;
`endif
               default: ;
            endcase
         end

         e_trap = s_trap;
         e_redir = s_trap || s_mret;
         if (s_trap) begin
            m_epc   = {pc[N-1:2], 2'b00};
            m_cause = (64'(s_async) << 63) + 64'(s_code);
            m_mpie  = o_mie;
            m_mie   = 0;
`ifdef TRAP_MTVAL_EN
            m_tval  = s_async ? '0 : tval;
`endif
            e_target = {o_tvec[N-1:2], 2'b00} +
                       ((o_tvec[1:0] == 2'd1 && s_async) ? 64'(s_code * 4) : 64'd0);
            m_drain = DC;
         end else if (s_mret) begin
            m_mie = o_mpie;
            m_mpie = 1;
            e_target = o_epc;
            m_drain = DC;
         end else if (s_busy) begin
            m_drain = m_drain - 1;
         end
         m_ip = irq;
      end
   end

   function automatic logic [N-1:0] m_read(input logic [11:0] a);
      case (a)
         12'h300: return (64'(m_mpie) << 7) | (64'(m_mie) << 3);
         12'h304: return 64'(m_ie);
         12'h305: return m_tvec;
         12'h341: return m_epc;
         12'h342: return m_cause;
`ifdef TRAP_MTVAL_EN
         12'h343: return m_tval;
`endif
         12'h344: return 64'(m_ip);
         default: return '0;
      endcase
   endfunction

   typedef struct {
      logic [11:0]  a;
      logic [N-1:0] d;
      logic [N-1:0] r;
   } csr_vec_t;

   csr_vec_t     tbl[12];
   logic [11:0]  addrs[7];
   int           cnt;

   initial begin
      tbl[0]  = '{12'h300, 64'hFFFF_FFFF_FFFF_FFFF, 64'h88};
      tbl[1]  = '{12'h300, 64'h0,                   64'h0};
      tbl[2]  = '{12'h304, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF};
      tbl[3]  = '{12'h304, 64'h0,                   64'h0};
      tbl[4]  = '{12'h305, 64'h1002,                64'h1000};
      tbl[5]  = '{12'h305, 64'h1003,                64'h1000};
      tbl[6]  = '{12'h305, 64'h2001,                64'h2001};
      tbl[7]  = '{12'h341, 64'h2007,                64'h2004};
      tbl[8]  = '{12'h342, 64'h8000_0000_0000_0005, 64'h8000_0000_0000_0005};
      tbl[9]  = '{12'h344, 64'hFFFF,                64'h0};
`ifdef TRAP_MTVAL_EN
      tbl[10] = '{12'h343, 64'h55,                  64'h55};
`else
      tbl[10] = '{12'h343, 64'h55,                  64'h0};
`endif
      tbl[11] = '{12'h123, 64'hABC,                 64'h0};
      addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h343, 12'h344};

      reset = 1'b1; exc = '0; irq = '0; mret = 1'b0; pc = '0;
      addr = '0; we = 1'b0; wdata = '0;
`ifdef TRAP_MTVAL_EN
      tval = '0;
`endif
      tick(); tick();
      reset = 1'b0;

      // reset state
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_trap", 64'(trap), 64'd0);
      check("rst_redirect", 64'(redir), 64'd0);
      check("rst_target", target, 64'd0);
      chk_rd("rst_mstatus", 12'h300, 64'd0);
      chk_rd("rst_mie", 12'h304, 64'd0);
      chk_rd("rst_mtvec", 12'h305, 64'd0);

      // CSR write/read table
      foreach (tbl[i]) begin
         csr_wr(tbl[i].a, tbl[i].d);
         chk_rd($sformatf("csr_tbl%0d", i), tbl[i].a, tbl[i].r);
      end

      // synchronous exception, direct mode
      csr_wr(12'h305, 64'h1000);
      csr_wr(12'h300, 64'h8);
      exc = 16'h0808; pc = 64'h2006;
      tick();
      idle();
      check("exc_trap", 64'(trap), 64'd1);
      check("exc_redirect", 64'(redir), 64'd1);
      check("exc_target", target, 64'h1000);
      check("exc_mcause", mcause, 64'd3);
      check("exc_mepc", mepc, 64'h2004);
      chk_rd("exc_mstatus", 12'h300, 64'h80);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (!busy) break;
         cnt++;
         tick();
      end
      check("exc_busy_len", 64'(cnt), 64'(DC));
      check("exc_trap_single", 64'(trap), 64'd0);

      // vectored interrupt with one cycle of mip latency
      csr_wr(12'h305, 64'h1001);
      csr_wr(12'h304, 64'h80);
      csr_wr(12'h300, 64'h8);
      irq = 16'h0080; pc = 64'h3000;
      tick();
      check("irq_latency", 64'(trap), 64'd0);
      tick();
      check("irq_trap", 64'(trap), 64'd1);
      check("irq_mcause", mcause, 64'h8000_0000_0000_0007);
      check("irq_target", target, 64'h101C);
      check("irq_mepc", mepc, 64'h3000);
      chk_rd("irq_mstatus", 12'h300, 64'h80);
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (trap) cnt++;
      end
      check("irq_no_retrap", 64'(cnt), 64'd0);
      irq = '0;
      tick(); tick();

      // mret restores MIE
      mret = 1'b1;
      tick();
      idle();
      check("mret_redirect", 64'(redir), 64'd1);
      check("mret_trap", 64'(trap), 64'd0);
      check("mret_target", target, 64'h3000);
      chk_rd("mret_mstatus", 12'h300, 64'h88);
      tick(); tick(); tick();
      check("mret_drained", 64'(busy), 64'd0);

      // exception and mret together: the trap wins
      exc = 16'h0004; mret = 1'b1; pc = 64'h5008;
      tick();
      idle();
      check("prio_trap", 64'(trap), 64'd1);
      check("prio_mcause", mcause, 64'd2);
      check("prio_mepc", mepc, 64'h5008);
      check("prio_target", target, 64'h1000);
      chk_rd("prio_mstatus", 12'h300, 64'h80);
      tick(); tick(); tick();

      // trap beats a same-cycle mepc write, then reset mid-drain
      exc = 16'h0020; pc = 64'h4444; we = 1'b1; addr = 12'h341; wdata = 64'hDEAD0;
      tick();
      idle();
      check("wr_mepc_lost", mepc, 64'h4444);
      check("wr_mcause", mcause, 64'd5);
      check("wr_busy", 64'(busy), 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rdrain_busy", 64'(busy), 64'd0);
      check("rdrain_trap", 64'(trap), 64'd0);
      check("rdrain_mcause", mcause, 64'd0);
      check("rdrain_mepc", mepc, 64'd0);
      check("rdrain_mtvec", mtvec, 64'd0);
      chk_rd("rdrain_mstatus", 12'h300, 64'd0);
      chk_rd("rdrain_mie", 12'h304, 64'd0);

      // randomized traffic against the model
      for (int it = 0; it < 2000; it++) begin
         exc   = ($urandom_range(0, 9) == 0) ? 16'($urandom) : '0;
         if ($urandom_range(0, 19) == 0) irq = 16'($urandom);
         mret  = ($urandom_range(0, 7) == 0);
         pc    = {$urandom, $urandom};
         we    = ($urandom_range(0, 3) == 0);
         addr  = addrs[$urandom_range(0, 6)];
         wdata = {$urandom, $urandom};
`ifdef TRAP_MTVAL_EN
         tval  = {$urandom, $urandom};
`endif
         #1;
         check("rnd_rdata", rdata, m_read(addr));
         tick();
         check("rnd_trap", 64'(trap), 64'(e_trap));
         check("rnd_redirect", 64'(redir), 64'(e_redir));
         if (e_redir) check("rnd_target", target, e_target);
         check("rnd_busy", 64'(busy), 64'(m_drain > 0));
         check("rnd_mcause", mcause, m_cause);
         check("rnd_mepc", mepc, m_epc);
         check("rnd_mtvec", mtvec, m_tvec);
      end
      idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
